inst_encoder: RTL

- Sequential instruction assembler/loader for the team's RV32 subset CPU.
- Accepts one symbolic instruction per handshake: an 11-bit execution code plus register indices and an immediate.
- Produces the 32-bit machine word that the core's instruction decoder recognises, and writes it into instruction RAM at an auto-incrementing address.
- Used by test harnesses and the boot loader to build programs in instruction memory.

---
 rtl/inst_encoder_if.sv | 25 ++
 rtl/inst_encoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder_if.sv
// Instruction-in handshake and instruction-RAM write bus for inst_encoder.
interface inst_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [10:0]       execution;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, execution, rd, rs1, rs2, imm,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, execution, rd, rs1, rs2, imm,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_encoder.sv
// Symbolic RV32-subset instruction assembler that loads encoded words into instruction RAM.
// Optional immediate range/alignment checking is enabled by defining ENC_RANGE_CHECK_EN.
module inst_encoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    inst_encoder_if.slave     bus,
    input  logic              restart,
    output logic              halted,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   inst_count
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ENC   = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_ERR   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [10:0] EX_LW   = 11'h001;
    localparam logic [10:0] EX_SLLI = 11'h002;
    localparam logic [10:0] EX_AND  = 11'h003;
    localparam logic [10:0] EX_SW   = 11'h004;
    localparam logic [10:0] EX_BEQ  = 11'h008;
    localparam logic [10:0] EX_ADD  = 11'h010;
    localparam logic [10:0] EX_SUB  = 11'h020;
    localparam logic [10:0] EX_SLL  = 11'h040;
    localparam logic [10:0] EX_XOR  = 11'h080;
    localparam logic [10:0] EX_OR   = 11'h100;
    localparam logic [10:0] EX_JAL  = 11'h200;
    localparam logic [10:0] EX_HALT = 11'h400;

    localparam logic [6:0] OP_R = 7'b0110011;

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [10:0] exe_q;
    logic [4:0]  rd_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [31:0] imm_q;
    logic [31:0] word;
    logic        illegal;
    logic        is_halt;
    logic        range_bad;
    logic        enc_fail;
    logic [1:0]  code_sel;
    logic        transfer;

    assign transfer = bus.in_valid && bus.in_ready;

    // Machine-word encoding of the latched instruction
    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        is_halt = 1'b0;
        case (exe_q)
            EX_LW:   word = {imm_q[11:0], rs1_q, 3'b010, rd_q, 7'b0000011};
            EX_SLLI: word = {7'b0, imm_q[4:0], rs1_q, 3'b001, rd_q, 7'b0010011};
            EX_SW:   word = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], 7'b0100011};
            EX_BEQ:  word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000,
                             imm_q[4:1], imm_q[11], 7'b1100011};
            EX_ADD:  word = {7'b0000000, rs2_q, rs1_q, 3'b000, rd_q, OP_R};
            EX_SUB:  word = {7'b0100000, rs2_q, rs1_q, 3'b000, rd_q, OP_R};
            EX_SLL:  word = {7'b0000000, rs2_q, rs1_q, 3'b001, rd_q, OP_R};
            EX_XOR:  word = {7'b0000000, rs2_q, rs1_q, 3'b100, rd_q, OP_R};
            EX_OR:   word = {7'b0000000, rs2_q, rs1_q, 3'b110, rd_q, OP_R};
            EX_AND:  word = {7'b0000000, rs2_q, rs1_q, 3'b111, rd_q, OP_R};
            EX_JAL:  word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, 7'b1101111};
            EX_HALT: begin
                word    = 32'h0010_0073;
                is_halt = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic signed [31:0] imm_s;
    assign imm_s = $signed(imm_q);

    always_comb begin
        range_bad = 1'b0;
        case (exe_q)
            EX_LW, EX_SW: range_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            EX_SLLI:      range_bad = (imm_s < 32'sd0) || (imm_s > 32'sd31);
            EX_BEQ:       range_bad = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm_q[0];
            EX_JAL:       range_bad = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm_q[0];
            default:      range_bad = 1'b0;
        endcase
    end
`else
    // Without checking, high immediate bits are simply truncated away
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm_q[31:21];
    assign range_bad     = 1'b0;
`endif

    // Error priority: illegal code, then memory full, then immediate range
    always_comb begin
        code_sel = 2'b00;
        if (illegal)        code_sel = 2'b01;
        else if (full)      code_sel = 2'b11;
        else if (range_bad) code_sel = 2'b10;
    end

    assign enc_fail = illegal || full || range_bad;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (transfer) state_nx = S_ENC;
            S_ENC:   state_nx = enc_fail ? S_ERR : S_WRITE;
            S_WRITE: state_nx = is_halt ? S_DONE : S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            S_DONE:  if (restart) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Registered outputs, field latches, write pointer and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= BASE_PTR;
            bus.mem_wdata <= 32'h0;
            halted        <= 1'b0;
            full          <= 1'b0;
            err           <= 1'b0;
            err_code      <= 2'b00;
            inst_count    <= '0;
            exe_q         <= 11'h0;
            rd_q          <= 5'h0;
            rs1_q         <= 5'h0;
            rs2_q         <= 5'h0;
            imm_q         <= 32'h0;
        end else begin
            bus.in_ready <= (state_nx == S_IDLE);
            bus.mem_we   <= (state_nx == S_WRITE);
            err          <= (state_nx == S_ERR);

            if (state == S_IDLE && transfer) begin
                exe_q <= bus.execution;
                rd_q  <= bus.rd;
                rs1_q <= bus.rs1;
                rs2_q <= bus.rs2;
                imm_q <= bus.imm;
            end

            if (state == S_ENC) begin
                if (enc_fail) err_code      <= code_sel;
                else          bus.mem_wdata <= word;
            end

            // The last word leaves the pointer on the final address rather than wrapping
            if (state == S_WRITE) begin
                inst_count <= inst_count + CNT_W'(1);
                if (inst_count + CNT_W'(1) == CAPACITY) full <= 1'b1;
                else                                     bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
                if (is_halt) halted <= 1'b1;
            end

            if (state == S_DONE && restart) begin
                bus.mem_addr <= BASE_PTR;
                inst_count   <= '0;
                halted       <= 1'b0;
                full         <= 1'b0;
            end
        end
    end
endmodule
